// File: rtl/mem_bridge_if.sv
// mem_bridge_if: word-wide valid/ready memory bus with byte strobes and a
// separate read-data return channel (rvalid/rdata).
interface mem_bridge_if;
  logic        bus_valid;
  logic        bus_ready;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  // Bridge side: issues requests, receives handshake and read data
  modport master (
    output bus_valid, bus_we, bus_addr, bus_wstrb, bus_wdata,
    input  bus_ready, bus_rvalid, bus_rdata
  );

  // Memory side: accepts requests, returns read data
  modport slave (
    input  bus_valid, bus_we, bus_addr, bus_wstrb, bus_wdata,
    output bus_ready, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/mem_bridge.sv
// mem_bridge: load/store and fetch bridge between the datapath memory port
// and a word-wide valid/ready bus. Store data is lane-replicated with byte
// strobes; load data comes back lane-shifted and sign/zero-extended, with a
// one-cycle core_done pulse marking completion.
// Optional feature macro: MEM_MISALIGN_TRAP_EN -- when defined, misaligned
// half/word accesses complete with core_err=1 and never reach the bus.
module mem_bridge (
  input  logic         clk,
  input  logic         rst,
  input  logic         core_req,
  input  logic         core_we,
  input  logic [31:0]  core_addr,
  input  logic [2:0]   core_size,
  input  logic [31:0]  core_wdata,
  output logic [31:0]  core_rdata,
  output logic         core_done,
  output logic         core_err,
  mem_bridge_if.master bus
);

  typedef enum logic [2:0] {IDLE, REQ, RESP, DONE, ERR} state_t;

  state_t      state, state_next;
  logic        acc_we;
  logic [31:0] acc_addr;
  logic [2:0]  acc_size;
  logic [31:0] acc_wdata;
  logic [1:0]  off;
  logic        misaligned;
  logic [3:0]  lane_strb;
  logic [31:0] lane_wdata;
  logic [31:0] lane_rdata;
  logic [31:0] load_data;

  assign off       = acc_addr[1:0];
  assign bus.bus_addr  = {acc_addr[31:2], 2'b00};
  assign bus.bus_wdata = lane_wdata;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Capture the access at acceptance so the bus payload cannot move while REQ waits
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_we    <= 1'b0;
      acc_addr  <= '0;
      acc_size  <= '0;
      acc_wdata <= '0;
    end else if (state == IDLE && core_req) begin
      acc_we    <= core_we;
      acc_addr  <= core_addr;
      acc_size  <= core_size;
      acc_wdata <= core_wdata;
    end
  end

  // Alignment check on the incoming request; only meaningful when trapping is built in
  always_comb begin
    misaligned = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    case (core_size[1:0])
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = core_addr[0];
      default: misaligned = |core_addr[1:0];
    endcase
`endif
  end

  // Next-state and handshake outputs; bus signals only live in REQ
  always_comb begin
    state_next    = state;
    bus.bus_valid = 1'b0;
    bus.bus_we    = 1'b0;
    bus.bus_wstrb = 4'h0;
    core_done     = 1'b0;
    core_err      = 1'b0;
    unique case (state)
      IDLE: begin
        if (core_req) state_next = misaligned ? ERR : REQ;
      end
      REQ: begin
        bus.bus_valid = 1'b1;
        bus.bus_we    = acc_we;
        bus.bus_wstrb = lane_strb;
        if (bus.bus_ready) state_next = acc_we ? DONE : RESP;
      end
      RESP: begin
        if (bus.bus_rvalid) state_next = DONE;
      end
      DONE: begin
        core_done  = 1'b1;
        state_next = IDLE;
      end
      ERR: begin
        core_done  = 1'b1;
`ifdef MEM_MISALIGN_TRAP_EN
        core_err   = 1'b1;
`endif
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Byte strobes and lane replication; half uses only addr[1], word ignores the offset
  always_comb begin
    lane_strb  = 4'hF;
    lane_wdata = acc_wdata;
    case (acc_size[1:0])
      2'd0: begin
        lane_strb  = 4'b0001 << off;
        lane_wdata = {4{acc_wdata[7:0]}};
      end
      2'd1: begin
        lane_strb  = 4'b0011 << {off[1], 1'b0};
        lane_wdata = {2{acc_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Shift the addressed lane down and extend; size[2] selects zero-extension
  always_comb begin
    lane_rdata = bus.bus_rdata;
    load_data  = bus.bus_rdata;
    case (acc_size[1:0])
      2'd0: begin
        lane_rdata = bus.bus_rdata >> {off, 3'b000};
        load_data  = acc_size[2] ? {24'd0, lane_rdata[7:0]}
                                 : {{24{lane_rdata[7]}}, lane_rdata[7:0]};
      end
      2'd1: begin
        lane_rdata = bus.bus_rdata >> {off[1], 4'b0000};
        load_data  = acc_size[2] ? {16'd0, lane_rdata[15:0]}
                                 : {{16{lane_rdata[15]}}, lane_rdata[15:0]};
      end
      default: ;
    endcase
  end

  // Load result register; holds across stores and traps until the next load returns
  always_ff @(posedge clk) begin
    if (rst)                                core_rdata <= '0;
    else if (state == RESP && bus.bus_rvalid) core_rdata <= load_data;
  end

endmodule

// File: tb/tb_mem_bridge.sv
// tb_mem_bridge: randomized self-checking bench for mem_bridge. A cycle-level
// bus responder drives ready/rvalid with programmable wait states; expected
// strobes, replicated data, load results and completion cycles come from a
// byte-oriented reference model.
module tb_mem_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req;
  logic        core_we;
  logic [31:0] core_addr;
  logic [2:0]  core_size;
  logic [31:0] core_wdata;
  logic [31:0] core_rdata;
  logic        core_done;
  logic        core_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] model_rdata;

  int          obs_done_cycle;
  int          obs_done_count;
  int          obs_hs;
  int          obs_valid_cycles;
  bit          obs_err;
  bit          obs_payload_changed;
  bit          obs_extra;
  logic [31:0] obs_addr;
  logic [31:0] obs_wdata;
  logic [3:0]  obs_wstrb;
  logic        obs_we;

  mem_bridge_if bus_if ();

  mem_bridge dut (
    .clk        (clk),
    .rst        (rst),
    .core_req   (core_req),
    .core_we    (core_we),
    .core_addr  (core_addr),
    .core_size  (core_size),
    .core_wdata (core_wdata),
    .core_rdata (core_rdata),
    .core_done  (core_done),
    .core_err   (core_err),
    .bus        (bus_if)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // ---------------- reference model ----------------
  function automatic int acc_bytes(input logic [2:0] size);
    case (size[1:0])
      2'd0:    return 1;
      2'd1:    return 2;
      default: return 4;
    endcase
  endfunction

  // Lane offset of the access: the byte address rounded down to the access size
  function automatic int acc_off(input logic [31:0] addr, input logic [2:0] size);
    int n = acc_bytes(size);
    return (int'(addr % 4) / n) * n;
  endfunction

  function automatic logic [3:0] model_strb(input logic [31:0] addr, input logic [2:0] size);
    int n = acc_bytes(size);
    int v = ((1 << n) - 1) << acc_off(addr, size);
    return v[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] wdata, input logic [2:0] size);
    logic [31:0] res;
    int n = acc_bytes(size);
    for (int i = 0; i < 4; i++) res[8*i +: 8] = wdata[8*(i % n) +: 8];
    return res;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] rword, input logic [31:0] addr,
                                             input logic [2:0] size);
    int n = acc_bytes(size);
    longint unsigned v    = 64'(rword) >> (8 * acc_off(addr, size));
    longint unsigned mask = (64'd1 << (8 * n)) - 1;
    if (n < 4) begin
      v = v & mask;
      if (!size[2] && ((v >> (8 * n - 1)) & 1) == 1) v = v | ~mask;
    end
    return v[31:0];
  endfunction

  function automatic bit model_trap(input logic [31:0] addr, input logic [2:0] size);
`ifdef MEM_MISALIGN_TRAP_EN
    return (addr % acc_bytes(size)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int model_done_cycle(input logic we, input bit trap, input int rdy, input int rv);
    if (trap) return 1;
    if (we)   return 2 + rdy;
    return 3 + rdy + rv;
  endfunction

  // ---------------- bus responder / access driver ----------------
  // Starts at a falling edge with the DUT idle; cycle 0 is the request cycle.
  task automatic run_access(input logic we, input logic [31:0] addr, input logic [2:0] size,
                            input logic [31:0] wdata, input logic [31:0] rword,
                            input int rdy_wait, input int rv_wait);
    int resp_cnt = 0;
    bit in_resp = 0;
    bit hs_now;
    obs_done_cycle = -1; obs_done_count = 0; obs_hs = 0; obs_valid_cycles = 0;
    obs_err = 0; obs_payload_changed = 0; obs_extra = 0;
    obs_addr = '0; obs_wdata = '0; obs_wstrb = '0; obs_we = 1'b0;
    core_req = 1'b1; core_we = we; core_addr = addr; core_size = size; core_wdata = wdata;
    for (int cyc = 1; cyc <= 60 && obs_done_count == 0; cyc++) begin
      @(negedge clk);
      core_req   = 1'b0;
      core_we    = ~we;
      core_addr  = $urandom;
      core_wdata = $urandom;
      bus_if.bus_ready  = 1'b0;
      bus_if.bus_rvalid = 1'b0;
      bus_if.bus_rdata  = $urandom;
      hs_now = 0;
      if (core_done) begin
        obs_done_count++;
        obs_done_cycle = cyc;
        obs_err = core_err;
      end
      if (bus_if.bus_valid) begin
        if (obs_valid_cycles == 0) begin
          obs_addr  = bus_if.bus_addr;
          obs_wdata = bus_if.bus_wdata;
          obs_wstrb = bus_if.bus_wstrb;
          obs_we    = bus_if.bus_we;
        end else if ({bus_if.bus_addr, bus_if.bus_wdata, bus_if.bus_wstrb, bus_if.bus_we} !==
                     {obs_addr, obs_wdata, obs_wstrb, obs_we}) begin
          obs_payload_changed = 1;
        end
        obs_valid_cycles++;
        if (obs_valid_cycles - 1 == rdy_wait) begin
          bus_if.bus_ready = 1'b1;
          obs_hs++;
          hs_now = 1;
        end
      end
      if (in_resp) begin
        if (resp_cnt == rv_wait) begin
          bus_if.bus_rvalid = 1'b1;
          bus_if.bus_rdata  = rword;
          in_resp = 0;
        end else begin
          resp_cnt++;
        end
      end
      if (hs_now && !we) begin
        in_resp  = 1;
        resp_cnt = 0;
      end
    end
    @(negedge clk);
    bus_if.bus_ready  = 1'b0;
    bus_if.bus_rvalid = 1'b0;
    if (core_done || bus_if.bus_valid) obs_extra = 1;
    if (obs_done_count == 0) begin
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_size = '0; core_wdata = '0;
    bus_if.bus_ready = 1'b0; bus_if.bus_rvalid = 1'b0; bus_if.bus_rdata = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus_if.bus_valid, bus_if.bus_we, bus_if.bus_wstrb, core_done, core_err} !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got valid=%b we=%b strb=%b done=%b err=%b required all 0",
               bus_if.bus_valid, bus_if.bus_we, bus_if.bus_wstrb, core_done, core_err);
    end
    checks++;
    if ({core_rdata, bus_if.bus_addr, bus_if.bus_wdata} !== 96'h0) begin
      errors++;
      $display("[TB] FAIL reset_data: got rdata=%h addr=%h wdata=%h required 0",
               core_rdata, bus_if.bus_addr, bus_if.bus_wdata);
    end
    rst = 1'b0;
    model_rdata = '0;
    @(negedge clk);
  endtask

  task automatic test_store_byte();
    run_access(1'b1, 32'h103, 3'b000, 32'h0000_00A5, 32'h0, 0, 0);
    checks++;
    if (obs_wstrb !== 4'b1000) begin
      errors++; $display("[TB] FAIL sb_strb: got %b required 1000", obs_wstrb);
    end
    checks++;
    if (obs_wdata !== 32'hA5A5_A5A5) begin
      errors++; $display("[TB] FAIL sb_wdata: got %h required a5a5a5a5", obs_wdata);
    end
    checks++;
    if (obs_addr !== 32'h100 || obs_we !== 1'b1) begin
      errors++; $display("[TB] FAIL sb_addr: got addr=%h we=%b required 00000100 we=1", obs_addr, obs_we);
    end
    checks++;
    if (obs_done_cycle !== 2 || obs_done_count !== 1) begin
      errors++; $display("[TB] FAIL sb_latency: got cycle=%0d count=%0d required 2/1", obs_done_cycle, obs_done_count);
    end
  endtask

  task automatic test_load_half();
    run_access(1'b0, 32'h202, 3'b001, 32'h0, 32'h8001_1234, 0, 0);
    checks++;
    if (core_rdata !== 32'hFFFF_8001) begin
      errors++; $display("[TB] FAIL lh_signed: got %h required ffff8001", core_rdata);
    end
    checks++;
    if (obs_done_cycle !== 3 || obs_wstrb !== 4'b1100) begin
      errors++; $display("[TB] FAIL lh_timing: got cycle=%0d strb=%b required 3/1100", obs_done_cycle, obs_wstrb);
    end
    run_access(1'b0, 32'h202, 3'b101, 32'h0, 32'h8001_1234, 0, 0);
    checks++;
    if (core_rdata !== 32'h0000_8001) begin
      errors++; $display("[TB] FAIL lhu_zero: got %h required 00008001", core_rdata);
    end
    model_rdata = 32'h0000_8001;
  endtask

  task automatic test_load_word_wait();
    logic [31:0] rword = $urandom;
    run_access(1'b0, 32'h400, 3'b010, 32'h0, rword, 3, 2);
    checks++;
    if (obs_done_cycle !== 8 || obs_done_count !== 1 || obs_extra !== 1'b0) begin
      errors++; $display("[TB] FAIL lw_wait_done: got cycle=%0d count=%0d extra=%b required 8/1/0",
                         obs_done_cycle, obs_done_count, obs_extra);
    end
    checks++;
    if (obs_valid_cycles !== 4 || obs_payload_changed !== 1'b0 || obs_hs !== 1) begin
      errors++; $display("[TB] FAIL lw_wait_hold: got valid_cycles=%0d changed=%b hs=%0d required 4/0/1",
                         obs_valid_cycles, obs_payload_changed, obs_hs);
    end
    checks++;
    if (core_rdata !== rword) begin
      errors++; $display("[TB] FAIL lw_wait_data: got %h required %h", core_rdata, rword);
    end
    model_rdata = rword;
  endtask

  task automatic test_misaligned();
    logic [31:0] rword = $urandom;
    run_access(1'b0, 32'h301, 3'b010, 32'h0, rword, 0, 0);
`ifdef MEM_MISALIGN_TRAP_EN
    checks++;
    if (obs_done_cycle !== 1 || obs_err !== 1'b1) begin
      errors++; $display("[TB] FAIL mis_trap: got cycle=%0d err=%b required 1/1", obs_done_cycle, obs_err);
    end
    checks++;
    if (obs_valid_cycles !== 0 || core_rdata !== model_rdata) begin
      errors++; $display("[TB] FAIL mis_nobus: got valid_cycles=%0d rdata=%h required 0/%h",
                         obs_valid_cycles, core_rdata, model_rdata);
    end
`else
    checks++;
    if (obs_addr !== 32'h300 || obs_done_cycle !== 3 || obs_err !== 1'b0) begin
      errors++; $display("[TB] FAIL mis_normal: got addr=%h cycle=%0d err=%b required 00000300/3/0",
                         obs_addr, obs_done_cycle, obs_err);
    end
    checks++;
    if (core_rdata !== rword) begin
      errors++; $display("[TB] FAIL mis_data: got %h required %h", core_rdata, rword);
    end
    model_rdata = rword;
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      logic        we    = 1'($urandom_range(0, 1));
      logic [31:0] addr  = $urandom;
      logic [2:0]  size  = 3'($urandom_range(0, 7));
      logic [31:0] wdata = $urandom;
      logic [31:0] rword = $urandom;
      int          rdy   = $urandom_range(0, 3);
      int          rv    = $urandom_range(0, 3);
      bit          trap  = model_trap(addr, size);
      run_access(we, addr, size, wdata, rword, rdy, rv);
      checks++;
      if (obs_done_count !== 1 || obs_extra !== 1'b0 ||
          obs_done_cycle !== model_done_cycle(we, trap, rdy, rv) || obs_err !== trap) begin
        errors++; $display("[TB] FAIL rnd_done[%0d]: got count=%0d cycle=%0d err=%b required 1/%0d/%b",
                           i, obs_done_count, obs_done_cycle, obs_err, model_done_cycle(we, trap, rdy, rv), trap);
      end
      if (!trap) begin
        checks++;
        if (obs_addr !== {addr[31:2], 2'b00} || obs_we !== we ||
            obs_wstrb !== model_strb(addr, size) || obs_wdata !== model_wdata(wdata, size)) begin
          errors++; $display("[TB] FAIL rnd_payload[%0d]: got addr=%h we=%b strb=%b wdata=%h required %h/%b/%b/%h",
                             i, obs_addr, obs_we, obs_wstrb, obs_wdata, {addr[31:2], 2'b00}, we,
                             model_strb(addr, size), model_wdata(wdata, size));
        end
        checks++;
        if (obs_valid_cycles !== rdy + 1 || obs_payload_changed !== 1'b0 || obs_hs !== 1) begin
          errors++; $display("[TB] FAIL rnd_hold[%0d]: got valid_cycles=%0d changed=%b hs=%0d required %0d/0/1",
                             i, obs_valid_cycles, obs_payload_changed, obs_hs, rdy + 1);
        end
        if (!we) model_rdata = model_load(rword, addr, size);
      end else begin
        checks++;
        if (obs_valid_cycles !== 0) begin
          errors++; $display("[TB] FAIL rnd_trapbus[%0d]: got valid_cycles=%0d required 0", i, obs_valid_cycles);
        end
      end
      checks++;
      if (core_rdata !== model_rdata) begin
        errors++; $display("[TB] FAIL rnd_rdata[%0d]: got %h required %h", i, core_rdata, model_rdata);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit bad_done = 0;
    bit bad_valid = 0;
    run_access(1'b0, 32'h10, 3'b010, 32'h0, 32'hDEAD_BEEF, 0, 0);
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h40; core_size = 3'b010;
    @(negedge clk);
    core_req = 1'b0;
    bus_if.bus_ready = 1'b1;
    @(negedge clk);
    bus_if.bus_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    if (bus_if.bus_valid) bad_valid = 1;
    if (core_done) bad_done = 1;
    @(negedge clk);
    bus_if.bus_rvalid = 1'b1;
    bus_if.bus_rdata  = 32'h1234_5678;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      bus_if.bus_rvalid = 1'b0;
      if (core_done) bad_done = 1;
      if (bus_if.bus_valid) bad_valid = 1;
    end
    checks++;
    if (bad_done !== 1'b0 || bad_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL rst_mid_quiet: got done_seen=%b valid_seen=%b required 0/0", bad_done, bad_valid);
    end
    checks++;
    if (core_rdata !== 32'h0) begin
      errors++; $display("[TB] FAIL rst_mid_rdata: got %h required 00000000", core_rdata);
    end
    model_rdata = '0;
  endtask

  // With core_req held high each access needs DONE plus the accepting IDLE cycle,
  // so bus_valid rises every third cycle.
  task automatic test_back_to_back();
    logic [31:0] w [3];
    int          vstart [3];
    int          dcyc [3];
    logic [31:0] vdata [3];
    int          done_seen = 0;
    int          valids = 0;
    bit          extra = 0;
    for (int i = 0; i < 3; i++) begin
      w[i] = $urandom; vstart[i] = -1; dcyc[i] = -1; vdata[i] = '0;
    end
    core_req = 1'b1; core_we = 1'b1; core_addr = 32'h500; core_size = 3'b010; core_wdata = w[0];
    bus_if.bus_ready = 1'b1;
    for (int cyc = 1; cyc <= 30 && done_seen < 3; cyc++) begin
      @(negedge clk);
      if (bus_if.bus_valid) begin
        if (valids < 3) begin vstart[valids] = cyc; vdata[valids] = bus_if.bus_wdata; end
        valids++;
      end
      if (core_done) begin
        if (done_seen < 3) dcyc[done_seen] = cyc;
        done_seen++;
        if (done_seen < 3) core_wdata = w[done_seen];
        else               core_req = 1'b0;
      end
    end
    core_req = 1'b0;
    bus_if.bus_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      if (bus_if.bus_valid || core_done) extra = 1;
    end
    checks++;
    if (done_seen !== 3 || valids !== 3 || extra !== 1'b0) begin
      errors++; $display("[TB] FAIL b2b_count: got done=%0d valid_cycles=%0d extra=%b required 3/3/0",
                         done_seen, valids, extra);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (vstart[i] !== 1 + 3 * i || dcyc[i] !== 2 + 3 * i || vdata[i] !== w[i]) begin
        errors++; $display("[TB] FAIL b2b_access[%0d]: got valid@%0d done@%0d wdata=%h required %0d/%0d/%h",
                           i, vstart[i], dcyc[i], vdata[i], 1 + 3 * i, 2 + 3 * i, w[i]);
      end
    end
    checks++;
    if (core_rdata !== model_rdata) begin
      errors++; $display("[TB] FAIL b2b_rdata_hold: got %h required %h", core_rdata, model_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_store_byte();
    test_load_half();
    test_load_word_wait();
    test_misaligned();
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
